ibex_pmp_csr_regs: RTL and testbench
====================================

Name: ibex_pmp_csr_regs

Overview:
- Owns the PMP and Smepmp CSR state: pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh.
- Legalises CSR-side writes, enforcing WARL, lock, TOR-lock, MML and RLB rules.
- Drives registered pmp_cfg/pmp_addr/mseccfg into the PMP access checker.
- Serves CSR reads with a one-cycle registered response and pulses a change strobe for fetch flush.

Parameters:
PMPGranularity, 0, NAPOT/TOR granule; 0 = 4 byte, G = 2^(G+2) byte
PMPNumRegions, 4, implemented regions, 1..16

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
csr_we_i  in  1  write strobe, single cycle
csr_re_i  in  1  read strobe, single cycle
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  write data
csr_rdata_o  out  32  read data, valid when csr_rvalid_o
csr_rvalid_o  out  1  read response strobe
csr_err_o  out  1  illegal address strobe (one cycle after access)
csr_pmp_cfg_o  out  pmp_cfg_t x PMPNumRegions  region configs
csr_pmp_addr_o  out  34 x PMPNumRegions  {pmpaddr[31:0],2'b00}
csr_pmp_mseccfg_o  out  pmp_mseccfg_t  {rlb,mmwp,mml}
pmp_cfg_changed_o  out  1  pulse: any PMP state actually changed

Behaviour:
- Reset (rst_ni low, async): all cfg, addr and mseccfg fields 0; csr_rdata_o=0, csr_rvalid_o=0, csr_err_o=0, pmp_cfg_changed_o=0.
- Address map:
  - 0x3A0-0x3A3 pmpcfg0-3: byte k maps to region 4n+k; bits are L=7, A=4:3, X=2, W=1, R=0; bits 6:5 read 0.
  - 0x3B0-0x3BF pmpaddr0-15.
  - 0x747 mseccfg: bit0 MML, bit1 MMWP, bit2 RLB.
  - 0x757 mseccfgh: reads 0, writes ignored.
  - Any other address with we or re: csr_err_o=1 next cycle, no state change, rdata=0.
- Regions >= PMPNumRegions read 0, ignore writes, no error.
- Writes: take effect on the next clock edge. All legality checks use pre-write state. Each pmpcfg byte is legalised independently.
- pmpcfg byte write is ignored if any of:
  - current L=1 and RLB=0
  - new {R,W}={0,1} and MML=0
  - MML=1, RLB=0, new L=1 and (new X=1 or new {R,W}={0,1})
- pmpcfg mode legalisation: if PMPGranularity>0 and the written A is NA4, the stored A is OFF and the other fields are stored as written.
- pmpaddr[i] write is ignored when RLB=0 and either:
  - cfg[i].L=1, or
  - i+1 < PMPNumRegions with cfg[i+1].L=1 and cfg[i+1].A=TOR.
- pmpaddr[i] otherwise stores all 32 bits as written.
- pmpaddr read-back:
  - NAPOT and G>=2: bits[G-2:0] read 1.
  - OFF/TOR and G>=1: bits[G-1:0] read 0.
  - Stored bits are unchanged by read masking.
- mseccfg write:
  - MML and MMWP are set-only and never cleared except by reset.
  - RLB may always be cleared.
  - Setting RLB is ignored if RLB=0 and any cfg[i].L=1.
- Reads: csr_re_i at cycle N gives csr_rvalid_o=1 and csr_rdata_o at N+1. rdata holds its value until the next read. Simultaneous we and re to the same address return the pre-write value.
- pmp_cfg_changed_o: 1 in cycle N+1 iff the write at N changed any stored bit. Ignored or no-op writes do not pulse.
- Back-to-back accesses every cycle are supported; there is no stall.

Test Plan:
- Reset, then read 0x3A0 and 0x3B0 -> rvalid at N+1, rdata=0; all outputs 0; write 0x3A0=0x0000_000F -> cfg0 {L0,TOR,X,W,R}, changed pulse once.
- cfg0=0x8F (locked TOR); write pmpaddr0=0x1000 and cfg0=0x00 -> both ignored, cfg0 reads 0x8F, no changed pulse; write pmpaddr1 -> accepted.
- MML=0, write cfg byte 0x02 (R0W1) -> ignored; set mseccfg=0x1, repeat -> cfg reads 0x02; write mseccfg=0x0 -> MML stays 1.
- With a locked region present and RLB=0, write mseccfg=0x4 -> RLB stays 0; after reset, write RLB=1, then cfg0=0x8F, then cfg0=0x00 -> accepted.
- PMPGranularity=2, cfg0 NAPOT, pmpaddr0=0x0 -> reads 0x1; switch to TOR -> reads 0x0; write cfg A=NA4 -> A reads OFF.
- Access 0x3C0 -> csr_err_o=1 at N+1, no state change; PMPNumRegions=4, write pmpaddr7 -> reads 0, no error.

Source files
------------

// File: rtl/ibex_pmp_csr_regs.sv
// PMP / Smepmp CSR register file.
// Holds pmpcfg0-3 (as per-region configs), pmpaddr0-15 and mseccfg, legalises
// CSR writes (WARL, lock, TOR-lock, MML, RLB), serves registered CSR reads and
// flags any real state change so the core can flush prefetched instructions.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   csr_we_i/csr_re_i    single-cycle write / read strobes
//   csr_addr_i           12-bit CSR address
//   csr_wdata_i          write data
//   csr_rdata_o          read data, valid with csr_rvalid_o (held until next read)
//   csr_rvalid_o         read response strobe, one cycle after csr_re_i
//   csr_err_o            illegal-address strobe, one cycle after the access
//   csr_pmp_cfg_o        per region {L, A[1:0], X, W, R}
//   csr_pmp_addr_o       per region {pmpaddr[31:0], 2'b00}
//   csr_pmp_mseccfg_o    {rlb, mmwp, mml}
//   pmp_cfg_changed_o    pulse: previous cycle's write changed stored state
module ibex_pmp_csr_regs #(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               csr_we_i,
  input  logic                               csr_re_i,
  input  logic [11:0]                        csr_addr_i,
  input  logic [31:0]                        csr_wdata_i,
  output logic [31:0]                        csr_rdata_o,
  output logic                               csr_rvalid_o,
  output logic                               csr_err_o,
  output logic [PMPNumRegions-1:0][5:0]      csr_pmp_cfg_o,
  output logic [PMPNumRegions-1:0][33:0]     csr_pmp_addr_o,
  output logic [2:0]                         csr_pmp_mseccfg_o,
  output logic                               pmp_cfg_changed_o
);
  localparam int unsigned N = PMPNumRegions;
  // Read-back masks: NAPOT forces bits [G-2:0] to 1, OFF/TOR clears [G-1:0].
  localparam logic [31:0] NapotOnes = (PMPGranularity >= 2) ?
                                      (((32'd1 << PMPGranularity) >> 1) - 32'd1) : 32'd0;
  localparam logic [31:0] TorClr    = (32'd1 << PMPGranularity) - 32'd1;

  // cfg packing: [5]=L, [4:3]=A, [2]=X, [1]=W, [0]=R
  logic [N-1:0][5:0]  r_cfg,  w_cfg_nxt;
  logic [N-1:0][31:0] r_addr, w_addr_nxt;
  logic               r_mml, r_mmwp, r_rlb;
  logic               w_mml_nxt, w_mmwp_nxt, w_rlb_nxt;
  logic [31:0]        r_rdata;
  logic               r_rvalid, r_err, r_changed;

  logic               w_sel_cfg, w_sel_addr, w_sel_msec, w_sel_msech, w_legal;
  logic [N-1:0]       w_lock, w_tor_lock;
  logic [3:0][31:0]   w_cfg_words;
  logic [15:0][31:0]  w_addr_rd;
  logic [31:0]        w_rdata;
  logic               w_changed;

  assign w_sel_cfg   = (csr_addr_i[11:2] == 10'h0E8);
  assign w_sel_addr  = (csr_addr_i[11:4] == 8'h3B);
  assign w_sel_msec  = (csr_addr_i == 12'h747);
  assign w_sel_msech = (csr_addr_i == 12'h757);
  assign w_legal     = w_sel_cfg | w_sel_addr | w_sel_msec | w_sel_msech;

  for (genvar gi = 0; gi < 16; gi++) begin : g_rgn
    if (gi < N) begin : g_impl
      logic [7:0] w_b;
      logic [1:0] w_a;
      logic       w_cfg_hit, w_cfg_ign, w_addr_hit, w_addr_ign;

      assign w_b       = csr_wdata_i[8*(gi%4) +: 8];
      assign w_cfg_hit = csr_we_i & w_sel_cfg & (csr_addr_i[1:0] == 2'(gi/4));
      // Locked entry, reserved R=0/W=1 outside MML, or MML forbidding new
      // locked executable / shared-data rules without RLB.
      assign w_cfg_ign = (r_cfg[gi][5] & ~r_rlb)
                       | (~w_b[0] & w_b[1] & ~r_mml)
                       | (r_mml & ~r_rlb & w_b[7] & (w_b[2] | (~w_b[0] & w_b[1])));
      // NA4 is not representable above 4-byte granularity; it falls back to OFF.
      assign w_a = ((PMPGranularity > 0) && (w_b[4:3] == 2'b10)) ? 2'b00 : w_b[4:3];
      assign w_cfg_nxt[gi] = (w_cfg_hit & ~w_cfg_ign) ? {w_b[7], w_a, w_b[2:0]} : r_cfg[gi];

      if (gi + 1 < N) begin : g_tor
        assign w_tor_lock[gi] = r_cfg[gi+1][5] & (r_cfg[gi+1][4:3] == 2'b01);
      end else begin : g_last
        assign w_tor_lock[gi] = 1'b0;
      end

      assign w_addr_hit = csr_we_i & w_sel_addr & (csr_addr_i[3:0] == 4'(gi));
      assign w_addr_ign = ~r_rlb & (r_cfg[gi][5] | w_tor_lock[gi]);
      assign w_addr_nxt[gi] = (w_addr_hit & ~w_addr_ign) ? csr_wdata_i : r_addr[gi];

      assign w_lock[gi] = r_cfg[gi][5];
      assign w_cfg_words[gi/4][8*(gi%4) +: 8] = {r_cfg[gi][5], 2'b00, r_cfg[gi][4:0]};

      always_comb begin
        w_addr_rd[gi] = r_addr[gi];
        unique case (r_cfg[gi][4:3])
          2'b11:        w_addr_rd[gi] = r_addr[gi] | NapotOnes;
          2'b00, 2'b01: w_addr_rd[gi] = r_addr[gi] & ~TorClr;
          default:      w_addr_rd[gi] = r_addr[gi];
        endcase
      end

      assign csr_pmp_cfg_o[gi]  = r_cfg[gi];
      assign csr_pmp_addr_o[gi] = {r_addr[gi], 2'b00};
    end else begin : g_none
      assign w_cfg_words[gi/4][8*(gi%4) +: 8] = 8'h00;
      assign w_addr_rd[gi] = 32'h0;
    end
  end

  // MML/MMWP are sticky; RLB can only be raised while no region is locked.
  always_comb begin
    w_mml_nxt  = r_mml;
    w_mmwp_nxt = r_mmwp;
    w_rlb_nxt  = r_rlb;
    if (csr_we_i && w_sel_msec) begin
      w_mml_nxt  = r_mml  | csr_wdata_i[0];
      w_mmwp_nxt = r_mmwp | csr_wdata_i[1];
      w_rlb_nxt  = csr_wdata_i[2] & (r_rlb | ~(|w_lock));
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_sel_cfg)       w_rdata = w_cfg_words[csr_addr_i[1:0]];
    else if (w_sel_addr) w_rdata = w_addr_rd[csr_addr_i[3:0]];
    else if (w_sel_msec) w_rdata = {29'h0, r_rlb, r_mmwp, r_mml};
  end

  assign w_changed = (w_cfg_nxt != r_cfg) | (w_addr_nxt != r_addr) |
                     ({w_rlb_nxt, w_mmwp_nxt, w_mml_nxt} != {r_rlb, r_mmwp, r_mml});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg     <= '0;
      r_addr    <= '0;
      r_mml     <= 1'b0;
      r_mmwp    <= 1'b0;
      r_rlb     <= 1'b0;
      r_rdata   <= 32'h0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_cfg     <= w_cfg_nxt;
      r_addr    <= w_addr_nxt;
      r_mml     <= w_mml_nxt;
      r_mmwp    <= w_mmwp_nxt;
      r_rlb     <= w_rlb_nxt;
      r_rvalid  <= csr_re_i;
      r_err     <= (csr_we_i | csr_re_i) & ~w_legal;
      r_changed <= w_changed;
      // Read samples pre-write state, so we+re to one address returns old data.
      if (csr_re_i) r_rdata <= w_rdata;
    end
  end

  assign csr_rdata_o       = r_rdata;
  assign csr_rvalid_o      = r_rvalid;
  assign csr_err_o         = r_err;
  assign csr_pmp_mseccfg_o = {r_rlb, r_mmwp, r_mml};
  assign pmp_cfg_changed_o = r_changed;
endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Directed-vector bench for ibex_pmp_csr_regs (4 regions, 16-byte granule).
// The driver issues one access per cycle and queues the expected response;
// a monitor pops one entry per cycle and compares the registered outputs.
module tb_ibex_pmp_csr_regs;
  logic              clk, rst_n;
  logic              we, re;
  logic [11:0]       addr;
  logic [31:0]       wdata, rdata;
  logic              rvalid, err, chg;
  logic [3:0][5:0]   cfg_o;
  logic [3:0][33:0]  addr_o;
  logic [2:0]        msec_o;

  ibex_pmp_csr_regs #(.PMPGranularity(2), .PMPNumRegions(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we), .csr_re_i(re),
    .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
    .csr_rvalid_o(rvalid), .csr_err_o(err), .csr_pmp_cfg_o(cfg_o),
    .csr_pmp_addr_o(addr_o), .csr_pmp_mseccfg_o(msec_o),
    .pmp_cfg_changed_o(chg));

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        ch;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   armed;
  int   n_cmp, n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: the entry queued during cycle N is due after the edge ending N.
  always @(posedge clk) begin
    if (q.size() > 0) begin
      cur   = q.pop_front();
      armed = 1'b1;
    end else begin
      armed = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk({cur.nm, " rvalid"}, 64'(rvalid), 64'(cur.rv));
      if (cur.rv) chk({cur.nm, " rdata"}, 64'(rdata), 64'(cur.rd));
      chk({cur.nm, " err"}, 64'(err), 64'(cur.er));
      chk({cur.nm, " changed"}, 64'(chg), 64'(cur.ch));
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                     input logic erv, input logic [31:0] erd, input logic eer, input logic ech,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    we = w; re = r; addr = a; wdata = d;
    e.rv = erv; e.rd = erd; e.er = eer; e.ch = ech; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ech, input string nm);
    cyc(1'b1, 1'b0, a, d, 1'b0, 32'h0, 1'b0, ech, nm);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    cyc(1'b0, 1'b1, a, 32'h0, 1'b1, e, 1'b0, 1'b0, nm);
  endtask

  // Idle one cycle and let the monitor finish all queued checks.
  task automatic flush();
    cyc(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, " rdata"},  64'(rdata),  64'h0);
    chk({nm, " rvalid"}, 64'(rvalid), 64'h0);
    chk({nm, " err"},    64'(err),    64'h0);
    chk({nm, " chg"},    64'(chg),    64'h0);
    chk({nm, " cfg"},    64'(cfg_o),  64'h0);
    chk({nm, " addr"},   64'(|addr_o), 64'h0);
    chk({nm, " msec"},   64'(msec_o), 64'h0);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs(nm);
    rst_n = 1'b1;
  endtask

  initial begin
    we = 1'b0; re = 1'b0; addr = 12'h0; wdata = 32'h0;
    n_cmp = 0; n_bad = 0; armed = 1'b0;
    do_reset("reset");

    // reset state and first TOR config
    rd(12'h3A0, 32'h0, "rst_cfg0");
    rd(12'h3B0, 32'h0, "rst_addr0");
    wr(12'h3A0, 32'h0000_000F, 1'b1, "cfg0_tor");
    rd(12'h3A0, 32'h0000_000F, "cfg0_tor_rd");
    wr(12'h3A0, 32'h0000_000F, 1'b0, "cfg0_noop");
    flush();
    chk("cfg_o_tor", 64'(cfg_o), 64'h00000F);

    // lock and TOR-lock
    wr(12'h3A0, 32'h0000_008F, 1'b1, "cfg0_lock");
    wr(12'h3B0, 32'h0000_1000, 1'b0, "addr0_locked");
    wr(12'h3A0, 32'h0000_0000, 1'b0, "cfg0_locked");
    rd(12'h3A0, 32'h0000_008F, "cfg0_locked_rd");
    wr(12'h3B1, 32'h0000_2000, 1'b1, "addr1_wr");
    rd(12'h3B1, 32'h0000_2000, "addr1_rd");
    rd(12'h3B0, 32'h0000_0000, "addr0_rd");
    wr(12'h3A0, 32'h0088_008F, 1'b1, "cfg2_lock_tor");
    wr(12'h3B1, 32'h0000_3000, 1'b0, "addr1_torlock");
    rd(12'h3B1, 32'h0000_2000, "addr1_torlock_rd");
    wr(12'h3B2, 32'h0000_0001, 1'b0, "addr2_locked");
    wr(12'h3B3, 32'h0000_4000, 1'b1, "addr3_last");
    rd(12'h3B3, 32'h0000_4000, "addr3_rd");
    rd(12'h3A0, 32'h0088_008F, "cfg_word_rd");

    // R0W1 and MML
    wr(12'h3A0, 32'h0288_008F, 1'b0, "cfg3_r0w1");
    rd(12'h3A0, 32'h0088_008F, "cfg3_r0w1_rd");
    wr(12'h747, 32'h1, 1'b1, "mml_set");
    rd(12'h747, 32'h1, "mml_rd");
    wr(12'h3A0, 32'h0288_008F, 1'b1, "cfg3_r0w1_mml");
    rd(12'h3A0, 32'h0288_008F, "cfg3_mml_rd");
    wr(12'h747, 32'h0, 1'b0, "mml_sticky");
    rd(12'h747, 32'h1, "mml_sticky_rd");
    wr(12'h3A0, 32'h0288_848F, 1'b0, "cfg1_mml_lx");
    wr(12'h3A0, 32'h0288_828F, 1'b0, "cfg1_mml_lw");
    wr(12'h3A0, 32'h0288_818F, 1'b1, "cfg1_mml_lr");
    rd(12'h3A0, 32'h0288_818F, "cfg1_mml_rd");
    wr(12'h747, 32'h2, 1'b1, "mmwp_set");
    rd(12'h747, 32'h3, "mmwp_rd");
    wr(12'h747, 32'h4, 1'b0, "rlb_blocked");
    rd(12'h747, 32'h3, "rlb_blocked_rd");
    rd(12'h757, 32'h0, "msech_rd");
    wr(12'h757, 32'hFFFF_FFFF, 1'b0, "msech_wr");
    flush();
    chk("msec_o", 64'(msec_o), 64'h3);
    chk("cfg_o_mix", 64'(cfg_o), 64'h0A886F);
    chk("addr_o1", 64'(addr_o[1]), 64'h8000);

    // illegal addresses, unimplemented regions, we+re same address
    cyc(1'b1, 1'b0, 12'h3C0, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, "err_wr");
    cyc(1'b0, 1'b1, 12'h3C0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "err_rd");
    rd(12'h3A0, 32'h0288_818F, "post_err_rd");
    cyc(1'b0, 1'b1, 12'h3A4, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "err_rd2");
    wr(12'h3B7, 32'h0000_FFFF, 1'b0, "addr7_wr");
    rd(12'h3B7, 32'h0, "addr7_rd");
    wr(12'h3A1, 32'hFFFF_FFFF, 1'b0, "cfg1w_wr");
    rd(12'h3A1, 32'h0, "cfg1w_rd");
    cyc(1'b1, 1'b1, 12'h3B3, 32'h0000_5000, 1'b1, 32'h0000_4000, 1'b0, 1'b1, "we_re_same");
    rd(12'h3B3, 32'h0000_5000, "we_re_after");
    flush();

    // RLB
    do_reset("reset2");
    wr(12'h747, 32'h4, 1'b1, "rlb_set");
    rd(12'h747, 32'h4, "rlb_rd");
    wr(12'h3A0, 32'h0000_008F, 1'b1, "rlb_lock");
    wr(12'h3A0, 32'h0000_0000, 1'b1, "rlb_unlock");
    rd(12'h3A0, 32'h0, "rlb_unlock_rd");
    wr(12'h3A0, 32'h0000_008F, 1'b1, "rlb_relock_cfg");
    wr(12'h3B0, 32'h0000_0010, 1'b1, "rlb_addr");
    rd(12'h3B0, 32'h0000_0010, "rlb_addr_rd");
    wr(12'h747, 32'h0, 1'b1, "rlb_clear");
    wr(12'h747, 32'h4, 1'b0, "rlb_reset_blocked");
    rd(12'h747, 32'h0, "rlb_clear_rd");

    // granularity read masks and NA4 legalisation
    wr(12'h3A0, 32'h1800_008F, 1'b1, "cfg3_napot");
    wr(12'h3B3, 32'h0, 1'b0, "addr3_noop");
    rd(12'h3B3, 32'h1, "napot_rd");
    wr(12'h3B3, 32'h0000_0103, 1'b1, "addr3_wr");
    rd(12'h3B3, 32'h0000_0103, "napot_rd2");
    wr(12'h3A0, 32'h0800_008F, 1'b1, "cfg3_tor");
    rd(12'h3B3, 32'h0000_0100, "tor_rd");
    wr(12'h3A0, 32'h1700_008F, 1'b1, "cfg3_na4");
    rd(12'h3A0, 32'h0700_008F, "na4_rd");
    flush();
    chk("addr_o3", 64'(addr_o[3]), 64'h40C);
    chk("cfg_o_na4", 64'(cfg_o), 64'h1C002F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
